// File: rtl/shift_ctrl_pkg.sv
// Shared types and default timing constants for the shift-register sequencing controller.
package shift_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        LOAD     = 2'd1,
        WAIT_REL = 2'd2,
        CLEAR    = 2'd3
    } ctrl_state_t;

    // 10 ms at 100 MHz
    localparam int unsigned DefDebCycles  = 1_000_000;
    localparam int unsigned DefScanCycles = 100_000;
    localparam int unsigned DefClrCycles  = 2;

endpackage

// File: rtl/btn_debounce.sv
// Push-button conditioner: 2-flop synchronizer, stability debouncer and registered rise pulse.
module btn_debounce
    import shift_ctrl_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DefDebCycles
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic level,
    output logic rise
);

    localparam int unsigned CW = $clog2(DEB_CYCLES + 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          rise_q, rise_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // The level flips once DEB_CYCLES mismatching samples have been counted and one more
    // mismatch arrives; any agreeing sample zeroes the count.
    always_comb begin
        level_d = level_q;
        rise_d  = 1'b0;
        cnt_d   = '0;
        if (sync2_q != level_q) begin
            if (cnt_q == CW'(DEB_CYCLES)) begin
                level_d = sync2_q;
                rise_d  = sync2_q;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn;
            sync2_q <= sync1_q;
            level_q <= level_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign level = level_q;
    assign rise  = rise_q;

endmodule

// File: rtl/shift_load_ctrl.sv
// Load/clear sequencer for the left-shift display register plus the digit scan multiplexer.
module shift_load_ctrl
    import shift_ctrl_pkg::*;
#(
    parameter int unsigned DEPTH       = 4,
    parameter int unsigned DEB_CYCLES  = DefDebCycles,
    parameter int unsigned SCAN_CYCLES = DefScanCycles,
    parameter int unsigned CLR_CYCLES  = DefClrCycles
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     btn_load,
    input  logic                     btn_clear,
    input  logic                     full_in,
    output logic                     load,
    output logic                     reject,
    output logic                     shr_rst_n,
    output logic [$clog2(DEPTH)-1:0] digit_idx,
    output logic [DEPTH-1:0]         an_n
);

    localparam int unsigned DW = $clog2(DEPTH);
    localparam int unsigned SW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int unsigned CW = (CLR_CYCLES > 1) ? $clog2(CLR_CYCLES) : 1;

    logic load_level, load_rise;
    logic clear_level, clear_rise;

    btn_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_deb_load (
        .clk  (clk),
        .rst  (rst),
        .btn  (btn_load),
        .level(load_level),
        .rise (load_rise)
    );

    btn_debounce #(
        .DEB_CYCLES(DEB_CYCLES)
    ) u_deb_clear (
        .clk  (clk),
        .rst  (rst),
        .btn  (btn_clear),
        .level(clear_level),
        .rise (clear_rise)
    );

    ctrl_state_t   state_q, state_d;
    logic [CW-1:0] clr_cnt_q, clr_cnt_d;
    logic          load_q, load_d;
    logic          reject_q, reject_d;
    logic          shr_rst_n_q, shr_rst_n_d;

    always_comb begin
        state_d   = state_q;
        clr_cnt_d = clr_cnt_q;
        unique case (state_q)
            IDLE: begin
                if (clear_rise) begin
                    state_d = CLEAR;
                end else if (load_rise) begin
                    state_d = full_in ? WAIT_REL : LOAD;
                end
            end
            LOAD: state_d = WAIT_REL;
            WAIT_REL: begin
                if (clear_rise) begin
                    state_d = CLEAR;
                end else if (!load_level) begin
                    state_d = IDLE;
                end
            end
            CLEAR: begin
                if (clr_cnt_q == CW'(CLR_CYCLES - 1)) begin
                    clr_cnt_d = '0;
                    state_d   = load_level ? WAIT_REL : IDLE;
                end else begin
                    clr_cnt_d = clr_cnt_q + 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Strobes are registered off the next state so they line up with the state they belong to.
    assign load_d      = (state_q == IDLE) && (state_d == LOAD);
    assign reject_d    = (state_q == IDLE) && !clear_rise && load_rise && full_in;
    assign shr_rst_n_d = (state_d != CLEAR);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= IDLE;
            clr_cnt_q   <= '0;
            load_q      <= 1'b0;
            reject_q    <= 1'b0;
            shr_rst_n_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            clr_cnt_q   <= clr_cnt_d;
            load_q      <= load_d;
            reject_q    <= reject_d;
            shr_rst_n_q <= shr_rst_n_d;
        end
    end

    logic [SW-1:0]    scan_cnt_q, scan_cnt_d;
    logic [DW-1:0]    digit_q, digit_d;
    logic [DEPTH-1:0] an_n_q, an_n_d;
    logic             scan_wrap;

    always_comb begin
        scan_wrap  = (scan_cnt_q == SW'(SCAN_CYCLES - 1));
        scan_cnt_d = scan_wrap ? '0 : scan_cnt_q + 1'b1;
        digit_d    = digit_q;
        if (scan_wrap) begin
            digit_d = (digit_q == DW'(DEPTH - 1)) ? '0 : digit_q + 1'b1;
        end
        an_n_d = ~(DEPTH'(1) << digit_d);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            scan_cnt_q <= '0;
            digit_q    <= '0;
            an_n_q     <= {{(DEPTH - 1){1'b1}}, 1'b0};
        end else begin
            scan_cnt_q <= scan_cnt_d;
            digit_q    <= digit_d;
            an_n_q     <= an_n_d;
        end
    end

    assign load      = load_q;
    assign reject    = reject_q;
    assign shr_rst_n = shr_rst_n_q;
    assign digit_idx = digit_q;
    assign an_n      = an_n_q;

endmodule

// File: tb/tb_shift_load_ctrl.sv
// Self-checking bench for shift_load_ctrl with short debounce/scan/clear timing.
module tb_shift_load_ctrl;

    localparam int unsigned DEPTH = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       btn_load = 1'b0;
    logic       btn_clear = 1'b0;
    logic       full_in = 1'b0;
    logic       load, reject, shr_rst_n;
    logic [1:0] digit_idx;
    logic [3:0] an_n;

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    // Expected event cycles (pushed at stimulus) and observed event cycles (from the monitor).
    int exp_ld[$];
    int exp_rj[$];
    int exp_cl[$];
    int ld_obs[$];
    int rj_obs[$];
    int cl_obs[$];

    shift_load_ctrl #(
        .DEPTH      (4),
        .DEB_CYCLES (4),
        .SCAN_CYCLES(3),
        .CLR_CYCLES (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .btn_load (btn_load),
        .btn_clear(btn_clear),
        .full_in  (full_in),
        .load     (load),
        .reject   (reject),
        .shr_rst_n(shr_rst_n),
        .digit_idx(digit_idx),
        .an_n     (an_n)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (rst) begin
            if (load) ld_obs.push_back(cyc);
            if (reject) rj_obs.push_back(cyc);
            if (!shr_rst_n) cl_obs.push_back(cyc);
        end
    end

    task automatic settle();
        btn_load  = 1'b0;
        btn_clear = 1'b0;
        repeat (15) @(negedge clk);
        ld_obs.delete();
        rj_obs.delete();
        cl_obs.delete();
    endtask

    task automatic test_reset();
        rst = 1'b0;
        repeat (3) @(negedge clk);
        n_checks++;
        if (an_n !== 4'b1110) begin
            n_fail++;
            $display("FAIL reset_an_n: got %b expected 1110", an_n);
        end
        n_checks++;
        if (shr_rst_n !== 1'b0 || load !== 1'b0 || reject !== 1'b0 || digit_idx !== 2'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: got shr_rst_n=%b load=%b reject=%b digit=%0d expected 0 0 0 0",
                     shr_rst_n, load, reject, digit_idx);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_checks++;
        if (shr_rst_n !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_shr_rst_n: got %b expected 1", shr_rst_n);
        end
        settle();
    endtask

    task automatic test_clean_press();
        int e, o;
        @(negedge clk);
        btn_load = 1'b1;
        exp_ld.push_back(cyc + 8);
        repeat (20) @(negedge clk);
        while (exp_ld.size() > 0) begin
            e = exp_ld.pop_front();
            n_checks++;
            if (ld_obs.size() == 0) begin
                n_fail++;
                $display("FAIL clean_load_missing: got none expected cycle %0d", e);
            end else begin
                o = ld_obs.pop_front();
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL clean_load_cycle: got %0d expected %0d", o, e);
                end
            end
        end
        n_checks++;
        if (ld_obs.size() != 0 || rj_obs.size() != 0) begin
            n_fail++;
            $display("FAIL clean_extra: got %0d extra loads %0d rejects expected 0 0",
                     ld_obs.size(), rj_obs.size());
        end
        settle();
    endtask

    task automatic test_bounce();
        int e, o;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            btn_load = ((i / 2) % 2 == 0);
        end
        @(negedge clk);
        n_checks++;
        if (ld_obs.size() != 0) begin
            n_fail++;
            $display("FAIL bounce_early_load: got %0d loads expected 0", ld_obs.size());
        end
        btn_load = 1'b1;
        exp_ld.push_back(cyc + 8);
        repeat (20) @(negedge clk);
        while (exp_ld.size() > 0) begin
            e = exp_ld.pop_front();
            n_checks++;
            if (ld_obs.size() == 0) begin
                n_fail++;
                $display("FAIL bounce_load_missing: got none expected cycle %0d", e);
            end else begin
                o = ld_obs.pop_front();
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL bounce_load_cycle: got %0d expected %0d", o, e);
                end
            end
        end
        n_checks++;
        if (ld_obs.size() != 0) begin
            n_fail++;
            $display("FAIL bounce_extra_load: got %0d expected 0", ld_obs.size());
        end
        settle();
    endtask

    task automatic test_full();
        int e, o;
        @(negedge clk);
        full_in  = 1'b1;
        btn_load = 1'b1;
        exp_rj.push_back(cyc + 8);
        repeat (20) @(negedge clk);
        while (exp_rj.size() > 0) begin
            e = exp_rj.pop_front();
            n_checks++;
            if (rj_obs.size() == 0) begin
                n_fail++;
                $display("FAIL full_reject_missing: got none expected cycle %0d", e);
            end else begin
                o = rj_obs.pop_front();
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL full_reject_cycle: got %0d expected %0d", o, e);
                end
            end
        end
        n_checks++;
        if (ld_obs.size() != 0 || rj_obs.size() != 0) begin
            n_fail++;
            $display("FAIL full_extra: got %0d loads %0d extra rejects expected 0 0",
                     ld_obs.size(), rj_obs.size());
        end
        settle();
        full_in = 1'b0;
        @(negedge clk);
        btn_load = 1'b1;
        exp_ld.push_back(cyc + 8);
        repeat (20) @(negedge clk);
        while (exp_ld.size() > 0) begin
            e = exp_ld.pop_front();
            n_checks++;
            if (ld_obs.size() == 0) begin
                n_fail++;
                $display("FAIL full_then_load_missing: got none expected cycle %0d", e);
            end else begin
                o = ld_obs.pop_front();
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL full_then_load_cycle: got %0d expected %0d", o, e);
                end
            end
        end
        n_checks++;
        if (ld_obs.size() != 0 || rj_obs.size() != 0) begin
            n_fail++;
            $display("FAIL full_then_extra: got %0d loads %0d rejects expected 0 0",
                     ld_obs.size(), rj_obs.size());
        end
        settle();
    endtask

    task automatic test_simultaneous();
        int e, o;
        @(negedge clk);
        btn_load  = 1'b1;
        btn_clear = 1'b1;
        exp_cl.push_back(cyc + 8);
        exp_cl.push_back(cyc + 9);
        repeat (30) @(negedge clk);
        while (exp_cl.size() > 0) begin
            e = exp_cl.pop_front();
            n_checks++;
            if (cl_obs.size() == 0) begin
                n_fail++;
                $display("FAIL sim_clear_missing: got none expected cycle %0d", e);
            end else begin
                o = cl_obs.pop_front();
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL sim_clear_cycle: got %0d expected %0d", o, e);
                end
            end
        end
        n_checks++;
        if (cl_obs.size() != 0) begin
            n_fail++;
            $display("FAIL sim_clear_length: got %0d extra clear cycles expected 0", cl_obs.size());
        end
        n_checks++;
        if (ld_obs.size() != 0 || rj_obs.size() != 0) begin
            n_fail++;
            $display("FAIL sim_strobes: got %0d loads %0d rejects expected 0 0",
                     ld_obs.size(), rj_obs.size());
        end
        settle();
        @(negedge clk);
        btn_load = 1'b1;
        exp_ld.push_back(cyc + 8);
        repeat (20) @(negedge clk);
        while (exp_ld.size() > 0) begin
            e = exp_ld.pop_front();
            n_checks++;
            if (ld_obs.size() == 0) begin
                n_fail++;
                $display("FAIL sim_repress_missing: got none expected cycle %0d", e);
            end else begin
                o = ld_obs.pop_front();
                if (o !== e) begin
                    n_fail++;
                    $display("FAIL sim_repress_cycle: got %0d expected %0d", o, e);
                end
            end
        end
        n_checks++;
        if (ld_obs.size() != 0) begin
            n_fail++;
            $display("FAIL sim_repress_extra: got %0d expected 0", ld_obs.size());
        end
        settle();
    endtask

    task automatic test_scan();
        int k;
        int ed;
        logic [3:0] ea;
        logic [3:0] one;
        one = 4'b0001;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        rst = 1'b1;
        k = 0;
        repeat (24) begin
            @(posedge clk);
            k++;
            #1;
            ed = (k / 3) % DEPTH;
            ea = ~(one << ed);
            n_checks++;
            if (digit_idx !== 2'(ed) || an_n !== ea) begin
                n_fail++;
                $display("FAIL scan_step%0d: got digit=%0d an_n=%b expected digit=%0d an_n=%b",
                         k, digit_idx, an_n, ed, ea);
            end
            n_checks++;
            if ($countones(~an_n) != 1) begin
                n_fail++;
                $display("FAIL scan_onehot%0d: got an_n=%b expected exactly one zero", k, an_n);
            end
        end
        repeat (4) @(posedge clk);
        #2;
        rst = 1'b0;
        #1;
        n_checks++;
        if (digit_idx !== 2'd0 || an_n !== 4'b1110) begin
            n_fail++;
            $display("FAIL scan_async_reset: got digit=%0d an_n=%b expected digit=0 an_n=1110",
                     digit_idx, an_n);
        end
        @(negedge clk);
        rst = 1'b1;
        settle();
    endtask

    initial begin
        test_reset();
        test_clean_press();
        test_bounce();
        test_full();
        test_simultaneous();
        test_scan();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
